// File: rtl/mult_pkg.sv
// Shared constants and state type for the sequential shift-add multiplier.
// Optional feature macro used by mult_seq: MULT_ZERO_SKIP_EN.
package mult_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    typedef enum logic {
        M_IDLE,
        M_RUN
    } state_t;

endpackage

// File: rtl/mult_seq_cond_negate.sv
// Conditional two's-complement negate: out = neg ? -in : in.
// Serves both the operand magnitudes and the final product sign fix-up.
module cond_negate #(
    parameter int unsigned W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/mult_seq.sv
// Iterative 32x32 -> 64 shift-add multiplier (MULT/MULTU), falling-edge clocked.
// Define MULT_ZERO_SKIP_EN to finish zero-operand launches in a single cycle.
module mult_seq
    import mult_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplr;
    logic [WIDTH-1:0]   acc_hi;
    logic               neg;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] product;
    logic               launch;
    logic               finish;
    logic               zero_op;

    assign busy   = (state == M_RUN);
    assign launch = start && !busy;
    assign finish = busy && (cnt == CNT_LAST);

`ifdef MULT_ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    cond_negate #(.W(WIDTH)) u_abs_a (
        .neg (is_signed & a[WIDTH-1]),
        .in  (a),
        .out (abs_a)
    );

    cond_negate #(.W(WIDTH)) u_abs_b (
        .neg (is_signed & b[WIDTH-1]),
        .in  (b),
        .out (abs_b)
    );

    // 33-bit add keeps the carry that becomes acc_hi's MSB after the shift
    assign sum     = {1'b0, acc_hi} + (mplr[0] ? {1'b0, mcand} : '0);
    assign shifted = {sum, mplr[WIDTH-1:1]};

    cond_negate #(.W(2*WIDTH)) u_sign_fix (
        .neg (neg),
        .in  (shifted),
        .out (product)
    );

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state <= M_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            M_IDLE:  if (launch) state_next = M_RUN;
            M_RUN:   if (finish) state_next = M_IDLE;
            default: state_next = M_IDLE;
        endcase
    end

    // A zero-operand skip launches with an empty accumulator at the last count,
    // so the next edge completes through the normal path with product 0.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplr   <= '0;
            acc_hi <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                mcand  <= zero_op ? '0 : abs_a;
                mplr   <= zero_op ? '0 : abs_b;
                acc_hi <= '0;
                neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                cnt    <= zero_op ? CNT_LAST : '0;
            end else if (busy) begin
                {acc_hi, mplr} <= shifted;
                cnt            <= cnt + CNT_W'(1);
                if (finish) begin
                    {hi, lo} <= product;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner cases plus random operands
// against a plain 64-bit arithmetic reference.
module tb_mult_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [63:0] prev_prod = '0;

`ifdef MULT_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    mult_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            return sx * sy;
        end
        ux = x;
        uy = y;
        return ux * uy;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits for done, counting falling edges since launch; 40 bounds the wait.
    task automatic wait_done(output int unsigned k, input logic poke);
        k = 0;
        while (!done && k < 40) begin
            @(posedge clock);
            k++;
            if (poke && k == 10) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
                is_signed = ~is_signed;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic poke);
        logic [63:0] exp;
        int unsigned lat;
        int unsigned k;
        exp = model(s, x, y);
        lat = (ZSKIP && (x == 0 || y == 0)) ? 1 : 32;
        @(posedge clock);
        start = 1'b1;
        is_signed = s;
        a = x;
        b = y;
        @(posedge clock);
        start = 1'b0;
        check({tag, " busy_after_launch"}, 64'(busy), 64'd1);
        check({tag, " hold_prev"}, {hi, lo}, prev_prod);
        wait_done(k, poke);
        check({tag, " latency"}, 64'(k), 64'(lat));
        check({tag, " product"}, {hi, lo}, exp);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clock);
        check({tag, " done_drop"}, 64'(done), 64'd0);
        prev_prod = exp;
    endtask

    initial begin
        int unsigned k;
        int unsigned done_seen;
        logic [31:0] rx;
        logic [31:0] ry;
        logic        rs;

        reset = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clock);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        do_op("multu_7x6", 1'b0, 32'd7, 32'd6, 1'b0);
        check("multu_7x6 const", prev_prod, 64'h0000_0000_0000_002A);
        do_op("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        do_op("multu_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("mult_ffxff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("mult_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op("mult_poke", 1'b1, 32'h1234_5678, 32'h8765_4321, 1'b1);

        // Reset mid-run: everything clears at once and no done follows.
        @(posedge clock);
        start = 1'b1;
        is_signed = 1'b0;
        a = 32'd99;
        b = 32'd77;
        @(posedge clock);
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(posedge clock);
        reset = 1'b0;
        prev_prod = '0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clock);
            if (done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        // start held through completion: refused at the edge busy falls, taken one edge later.
        @(posedge clock);
        start = 1'b1;
        is_signed = 1'b0;
        a = 32'd11;
        b = 32'd13;
        @(posedge clock);
        is_signed = 1'b1;
        a = 32'h8000_0001;
        b = 32'h7FFF_FFFF;
        k = 0;
        while (!done && k < 40) begin
            @(posedge clock);
            k++;
        end
        check("b2b first latency", 64'(k), 64'd32);
        check("b2b first product", {hi, lo}, 64'd143);
        check("b2b not accepted", 64'(busy), 64'd0);
        @(posedge clock);
        start = 1'b0;
        check("b2b accepted", 64'(busy), 64'd1);
        check("b2b done_drop", 64'(done), 64'd0);
        wait_done(k, 1'b0);
        check("b2b second latency", 64'(k), 64'd32);
        check("b2b second product", {hi, lo}, model(1'b1, 32'h8000_0001, 32'h7FFF_FFFF));
        prev_prod = {hi, lo};
        @(posedge clock);

        do_op("multu_0x1234", 1'b0, 32'd0, 32'h1234, 1'b0);
        do_op("mult_m7x0", 1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom);
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: rx = 32'h8000_0000;
                1: ry = 32'hFFFF_FFFF;
                2: rx = 32'd0;
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), rs, rx, ry, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
